display_fifo_buffer: RTL
========================

# display_fifo_buffer

Parametrised character buffer for segmented alphanumeric displays (HPDL-1414 class and wider chains). It stores up to DEPTH characters written by an upstream source (UART/keyboard decoder) and manages a write cursor with wrap or scroll behaviour, backspace and a timed clear. It serves a 1-cycle-latency read port to the display scanner and substitutes a blinking caret character at the cursor position. It sits between the character source and the display multiplexer.

## Interface
- DEPTH, 16: number of character cells (≥2).
- DATA_W, 8: character width in bits.
- CARET_CHR, 8'h5F: caret glyph substituted at the cursor; DATA_W wide.
- FILL_CHR, 8'h20: glyph written by clear and backspace.
- BLINK_HALF, 6_000_000: caret half-period in clock cycles (≥1).
- ADDR_W (localparam): $clog2(DEPTH).

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_wr_valid  in  1  character write request.
- i_wr_data  in  DATA_W  character to write.
- o_wr_ready  out  1  high only in IDLE; a write or command is accepted when it is high.
- i_mode_scroll  in  1  1 = scroll at the end of the line, 0 = wrap; sampled per accepted write.
- i_cmd_clear  in  1  clear request.
- i_cmd_backspace  in  1  backspace request.
- i_caret_en  in  1  enables caret substitution on reads.
- i_rd_en  in  1  read request.
- i_rd_addr  in  ADDR_W  read cell index.
- o_rd_data  out  DATA_W  registered read data.
- o_rd_valid  out  1  pulses one cycle after an accepted i_rd_en.
- o_cursor  out  ADDR_W  cell the next write lands in.
- o_full  out  1  scroll-mode line-full flag.

## Operation
- FSM states:
  - CLEAR: writes FILL_CHR to cell clr_idx, one cell per cycle, for clr_idx = 0..DEPTH-1. After writing DEPTH-1 it goes to IDLE, with cursor=0 and full=0.
  - IDLE: normal operation.
- Reset: state=CLEAR, clr_idx=0, cursor=0, full=0, o_rd_data=0, o_rd_valid=0, blink phase=0, blink counter=0. Memory cells are not reset; CLEAR initialises them.
- Accepted operations in IDLE use the priority clear > backspace > write. Only one operation executes per cycle; lower-priority requests in the same cycle are dropped.
- Clear: next state is CLEAR with clr_idx=0.
- Write, not full: mem[cursor] <= data.
  - If cursor < DEPTH-1, cursor increments.
  - If cursor == DEPTH-1 and scroll=0, cursor <= 0.
  - If cursor == DEPTH-1 and scroll=1, cursor stays and full <= 1.
- Write, full, scroll=1: single-cycle shift mem[i] <= mem[i+1] for i < DEPTH-1, then mem[DEPTH-1] <= data. Cursor stays and full stays set.
- Write, full, scroll=0: treated as a normal write at DEPTH-1; cursor <= 0, full <= 0.
- Backspace:
  - If full: mem[DEPTH-1] <= FILL_CHR, full <= 0, cursor unchanged.
  - Else if cursor > 0: cursor-1, and FILL_CHR is written to the new cursor cell.
  - If cursor == 0 and not full: no-op.
- Blink: the counter counts 0..BLINK_HALF-1; at wrap it returns to 0 and the phase toggles. Any accepted write or backspace forces phase=1 and counter=0, so the caret is shown immediately.
- Read: o_rd_data <= mem[i_rd_addr], except that it returns CARET_CHR when all of the following hold: i_caret_en=1, phase=1, state=IDLE and i_rd_addr==cursor.
- Reads are accepted in any state.
- An out-of-range i_rd_addr (≥DEPTH) returns FILL_CHR.
- A read and a write to the same cell in the same cycle returns the old contents.

## Timing
- Read latency is 1 cycle. o_rd_valid is high in the cycle after i_rd_en is sampled, and o_rd_data holds its value until the next accepted read.
- Write/command effects, including o_cursor and o_full, are visible in the cycle after the accepting edge.
- After reset release, o_wr_ready rises after the DEPTH-th rising edge.
- A clear accepted at edge k keeps o_wr_ready low from k through k+DEPTH; it is high again after edge k+DEPTH.
- i_wr_valid held high with o_wr_ready low: nothing is written; the request stays pending until it is accepted.
- Reset asserted mid-CLEAR or mid-shift: everything returns to reset values asynchronously, CLEAR restarts from cell 0, and a partially completed shift is abandoned.

## Test plan
- Reset, DEPTH=16:
  - o_wr_ready=0 for 16 edges, then 1.
  - Reading all cells returns 8'h20.
  - o_cursor=0, o_full=0.
- Wrap mode:
  - Write 17 characters 'A'..'Q'.
  - cell 0='Q', cells 1..15='B'..'P', o_cursor=1, o_full=0.
- Scroll mode:
  - Write 'A'..'P': o_full=1, o_cursor=15.
  - Write 'Q': cells read 'B'..'Q'.
  - Backspace: cell 15=8'h20, o_full=0, o_cursor=15.
- Caret, BLINK_HALF=4, i_caret_en=1:
  - Write one character, then read the cursor cell every cycle.
  - Reads return 8'h5F for 4 cycles, then the stored character for 4 cycles, alternating.
  - With i_caret_en=0, the stored character is always returned.
- Priority:
  - Clear, backspace and write asserted together at cursor=5.
  - Only clear executes, o_wr_ready is low for 16 cycles, and the final contents are all 8'h20 with o_cursor=0.
- Reset mid-clear:
  - Assert i_rst_n=0 at clr_idx=7.
  - All outputs take reset values and a full 16-cycle clear follows.

Source files
------------

// File: rtl/display_fifo_buffer.sv
// Character buffer for segmented alphanumeric displays: cursor-driven writes with
// wrap or scroll, backspace, timed clear, and a 1-cycle read port with blinking caret.
module display_fifo_buffer #(
  parameter int                 DEPTH      = 16,
  parameter int                 DATA_W     = 8,
  parameter logic [DATA_W-1:0]  CARET_CHR  = 8'h5F,
  parameter logic [DATA_W-1:0]  FILL_CHR   = 8'h20,
  parameter int                 BLINK_HALF = 6_000_000,
  localparam int                ADDR_W     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_valid,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  input  logic              i_mode_scroll,
  input  logic              i_cmd_clear,
  input  logic              i_cmd_backspace,
  input  logic              i_caret_en,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic [ADDR_W-1:0] o_cursor,
  output logic              o_full
);

  localparam int                CNT_W      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0]  BLINK_LAST = CNT_W'(BLINK_HALF - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_L    = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e             state_r;
  logic [ADDR_W-1:0]  clr_idx_r;
  logic [ADDR_W-1:0]  cursor_r;
  logic               full_r;
  logic               wr_ready_r;
  logic [DATA_W-1:0]  mem_r [DEPTH];
  logic [CNT_W-1:0]   blink_cnt_r;
  logic               phase_r;
  logic [DATA_W-1:0]  rd_data_r;
  logic               rd_valid_r;

  logic               accept_s;
  logic               do_clear_s;
  logic               do_bs_s;
  logic               do_wr_s;
  logic               caret_hit_s;

  // Priority decode of the operation accepted this cycle: clear > backspace > write.
  always_comb begin
    accept_s    = (state_r == ST_IDLE);
    do_clear_s  = accept_s & i_cmd_clear;
    do_bs_s     = accept_s & ~i_cmd_clear & i_cmd_backspace;
    do_wr_s     = accept_s & ~i_cmd_clear & ~i_cmd_backspace & i_wr_valid;
    caret_hit_s = i_caret_en & phase_r & accept_s & (i_rd_addr == cursor_r);
  end

  // Control FSM: clear sweep, cursor movement and the scroll-full flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_CLEAR;
      clr_idx_r  <= '0;
      cursor_r   <= '0;
      full_r     <= 1'b0;
      wr_ready_r <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if (clr_idx_r == LAST_IDX) begin
            state_r    <= ST_IDLE;
            clr_idx_r  <= '0;
            cursor_r   <= '0;
            full_r     <= 1'b0;
            wr_ready_r <= 1'b1;
          end else begin
            clr_idx_r <= clr_idx_r + 1'b1;
          end
        end
        ST_IDLE: begin
          if (do_clear_s) begin
            state_r    <= ST_CLEAR;
            clr_idx_r  <= '0;
            wr_ready_r <= 1'b0;
          end else if (do_bs_s) begin
            // A full line erases its last cell in place; otherwise step back first.
            if (full_r) begin
              full_r <= 1'b0;
            end else if (cursor_r != '0) begin
              cursor_r <= cursor_r - 1'b1;
            end
          end else if (do_wr_s) begin
            if (cursor_r == LAST_IDX) begin
              if (i_mode_scroll) begin
                full_r <= 1'b1;
              end else begin
                cursor_r <= '0;
                full_r   <= 1'b0;
              end
            end else begin
              cursor_r <= cursor_r + 1'b1;
            end
          end
        end
        default: begin
          state_r    <= ST_CLEAR;
          clr_idx_r  <= '0;
          wr_ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Character storage; left unreset because the clear sweep initialises it.
  always_ff @(posedge i_clk) begin
    if (state_r == ST_CLEAR) begin
      mem_r[clr_idx_r] <= FILL_CHR;
    end else if (do_bs_s) begin
      if (full_r) begin
        mem_r[LAST_IDX] <= FILL_CHR;
      end else if (cursor_r != '0) begin
        mem_r[cursor_r - 1'b1] <= FILL_CHR;
      end
    end else if (do_wr_s) begin
      if (full_r && i_mode_scroll) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          mem_r[i] <= mem_r[i + 1];
        end
        mem_r[LAST_IDX] <= i_wr_data;
      end else begin
        mem_r[cursor_r] <= i_wr_data;
      end
    end
  end

  // Caret blink timer; edits restart it in the visible phase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      blink_cnt_r <= '0;
      phase_r     <= 1'b0;
    end else if (do_wr_s || do_bs_s) begin
      blink_cnt_r <= '0;
      phase_r     <= 1'b1;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_r <= '0;
      phase_r     <= ~phase_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + 1'b1;
    end
  end

  // Registered read port with caret substitution and out-of-range fill.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= i_rd_en;
      if (i_rd_en) begin
        if ({1'b0, i_rd_addr} >= DEPTH_L) begin
          rd_data_r <= FILL_CHR;
        end else if (caret_hit_s) begin
          rd_data_r <= CARET_CHR;
        end else begin
          rd_data_r <= mem_r[i_rd_addr];
        end
      end
    end
  end

  assign o_wr_ready = wr_ready_r;
  assign o_rd_data  = rd_data_r;
  assign o_rd_valid = rd_valid_r;
  assign o_cursor   = cursor_r;
  assign o_full     = full_r;

endmodule
